// File: rtl/mips_pkg.sv
// mips_pkg: shared ALU codes, opcode/funct fields, md_op encoding and md sequencer states
package mips_pkg;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_NOP  = 4'b1111;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_e;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} md_state_e;
  // MFHI/MTHI/MFLO/MTLO (0100xx) and MULT/MULTU/DIV/DIVU (0110xx)
  function automatic logic is_md_funct(input logic [5:0] f);
    return f[5:4] == 2'b01 && !f[2];
  endfunction
endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational aluop/opcode/funct to alucontrol decode with illegal flag
module alu_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [1:0] aluop,
  output logic [3:0] alucontrol,
  output logic       illegal
);
  // md-class functs decode to NOP but are legal; everything unlisted is illegal
  always_comb begin
    alucontrol = ALU_NOP;
    illegal = 1'b0;
    case (aluop)
      2'b00: alucontrol = ALU_ADD;
      2'b01: alucontrol = ALU_SUB;
      2'b10:
        case (opcode)
          OP_ADDI, OP_ADDIU: alucontrol = ALU_ADD;
          OP_ANDI:           alucontrol = ALU_AND;
          OP_ORI:            alucontrol = ALU_OR;
          OP_XORI:           alucontrol = ALU_XOR;
          OP_SLTI:           alucontrol = ALU_SLT;
          OP_SLTIU:          alucontrol = ALU_SLTU;
          default:           illegal = 1'b1;
        endcase
      default:
        case (funct)
          FN_ADD, FN_ADDU: alucontrol = ALU_ADD;
          FN_SUB, FN_SUBU: alucontrol = ALU_SUB;
          FN_AND:          alucontrol = ALU_AND;
          FN_OR:           alucontrol = ALU_OR;
          FN_XOR:          alucontrol = ALU_XOR;
          FN_NOR:          alucontrol = ALU_NOR;
          FN_SLT:          alucontrol = ALU_SLT;
          FN_SLTU:         alucontrol = ALU_SLTU;
          FN_SLL:          alucontrol = ALU_SLL;
          FN_SRL:          alucontrol = ALU_SRL;
          FN_SRA:          alucontrol = ALU_SRA;
          default:         illegal = !is_md_funct(funct);
        endcase
    endcase
  end
endmodule

// File: rtl/alu_control_md.sv
// alu_control_md: ALU control decode plus multiply/divide sequencer with HI/LO hazard stall
module alu_control_md
  import mips_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic       flush,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [1:0] aluop,
  output logic [3:0] alucontrol,
  output logic       illegal,
  output logic       md_start,
  output logic [1:0] md_op,
  output logic       md_busy,
  output logic       stall,
  output logic       hi_we,
  output logic       lo_we,
  output logic       hilo_src
);
  md_state_e        state;
  md_op_e           op_q;
  logic [CNT_W-1:0] cnt;
  logic             md_class, idle, start, mt, wb;
  alu_decode u_dec (
    .opcode(opcode),
    .funct(funct),
    .aluop(aluop),
    .alucontrol(alucontrol),
    .illegal(illegal)
  );
  assign md_class = valid && aluop == 2'b11 && is_md_funct(funct);
  assign idle     = state == S_IDLE;
  assign start    = rst_n && idle && !flush && md_class && funct[3];
  assign mt       = rst_n && idle && !flush && md_class && !funct[3] && funct[0];
  assign wb       = state == S_DONE && !flush;
  assign md_start = start;
  assign md_op    = start ? funct[1:0] : op_q;
  assign md_busy  = !idle;
  assign stall    = !idle && md_class;
  assign hi_we    = wb || (mt && !funct[1]);
  assign lo_we    = wb || (mt && funct[1]);
  assign hilo_src = mt;
  // sequencer: load latency on start, count down to DONE, flush/reset abandon the result
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= MD_MULT;
    end else if (flush) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (start) begin
      state <= funct[1] ? S_DIV : S_MUL;
      cnt   <= funct[1] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
      op_q  <= md_op_e'(funct[1:0]);
    end else if (state == S_DONE) begin
      state <= S_IDLE;
    end else if (!idle) begin
      cnt   <= cnt - 1'b1;
      state <= cnt == CNT_W'(1) ? S_DONE : state;
    end
endmodule

// File: tb/tb_alu_control_md.sv
// tb_alu_control_md: randomized scoreboard bench against a cycle-level behavioural model
module tb_alu_control_md;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;
  logic clk = 0, rst_n = 0, valid = 0, flush = 0;
  logic [5:0] opcode = 0, funct = 0;
  logic [1:0] aluop = 0;
  logic [3:0] alucontrol;
  logic illegal, md_start, md_busy, stall, hi_we, lo_we, hilo_src;
  logic [1:0] md_op;
  typedef struct packed {
    logic [3:0] ac;
    logic il, st;
    logic [1:0] op;
    logic bz, sl, hw, lw, hs;
  } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;
  int imm_map[int];
  int r_map[int];
  bit m_active = 0;
  int m_wr_at = 0;
  logic [1:0] m_op = 0;
  int cyc = 0;
  alu_control_md #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .flush(flush),
    .opcode(opcode), .funct(funct), .aluop(aluop),
    .alucontrol(alucontrol), .illegal(illegal), .md_start(md_start), .md_op(md_op),
    .md_busy(md_busy), .stall(stall), .hi_we(hi_we), .lo_we(lo_we), .hilo_src(hilo_src)
  );
  always #5 clk = ~clk;
  function automatic void ref_decode(input logic [1:0] ao, input logic [5:0] oc, input logic [5:0] fn,
                                     output logic [3:0] ac, output logic il);
    ac = 4'b1111;
    il = 0;
    if (ao == 2'b00) ac = 4'b0010;
    else if (ao == 2'b01) ac = 4'b0110;
    else if (ao == 2'b10) begin
      if (imm_map.exists(int'(oc))) ac = 4'(imm_map[int'(oc)]);
      else il = 1;
    end else if (r_map.exists(int'(fn))) ac = 4'(r_map[int'(fn)]);
    else il = !(fn inside {[6'b010000:6'b010011], [6'b011000:6'b011011]});
  endfunction
  // one EX cycle: apply inputs, predict outputs, advance the model
  task automatic step(input logic v, input logic fl, input logic rn, input logic [1:0] ao,
                      input logic [5:0] oc, input logic [5:0] fn);
    exp_t e;
    logic mdc, mt, busy, done, start;
    @(posedge clk);
    #1;
    valid = v; flush = fl; rst_n = rn; aluop = ao; opcode = oc; funct = fn;
    if (!rn) begin m_active = 0; m_op = 0; end
    ref_decode(ao, oc, fn, e.ac, e.il);
    mdc = v && ao == 2'b11 && (fn inside {[6'b010000:6'b010011], [6'b011000:6'b011011]});
    busy = m_active;
    done = busy && cyc == m_wr_at;
    start = rn && !busy && !fl && mdc && (fn inside {[6'b011000:6'b011011]});
    mt = rn && !busy && !fl && mdc && (fn == 6'b010001 || fn == 6'b010011);
    e.st = start;
    e.op = start ? fn[1:0] : m_op;
    e.bz = busy;
    e.sl = busy && mdc;
    e.hw = (done && !fl) || (mt && fn == 6'b010001);
    e.lw = (done && !fl) || (mt && fn == 6'b010011);
    e.hs = mt;
    q.push_back(e);
    if (fl) m_active = 0;
    else if (start) begin
      m_active = 1;
      m_wr_at = cyc + ((fn inside {6'b011010, 6'b011011}) ? DIV_LAT : MUL_LAT);
      m_op = fn[1:0];
    end else if (done) m_active = 0;
    cyc++;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 2'b00, 6'd0, 6'd0);
  endtask
  task automatic rop(input logic [5:0] fn);
    step(1, 0, 1, 2'b11, 6'd0, fn);
  endtask
  // compare every cycle's outputs against the oldest prediction
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        a = {alucontrol, illegal, md_start, md_op, md_busy, stall, hi_we, lo_we, hilo_src};
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL outputs t=%0t ac/il/start/op/busy/stall/hi/lo/src actual=%b/%b/%b/%b/%b/%b/%b/%b/%b required=%b/%b/%b/%b/%b/%b/%b/%b/%b",
                   $time, a.ac, a.il, a.st, a.op, a.bz, a.sl, a.hw, a.lw, a.hs,
                   e.ac, e.il, e.st, e.op, e.bz, e.sl, e.hw, e.lw, e.hs);
        end
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end
  initial begin
    logic [5:0] ops[$] = '{6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001110, 6'b001010, 6'b001011, 6'b100011, 6'b000100};
    logic [5:0] fns[$] = '{6'b011000, 6'b011001, 6'b011010, 6'b011011, 6'b010000, 6'b010001, 6'b010010, 6'b010011,
                           6'b100000, 6'b100010, 6'b100111, 6'b000011, 6'b101011, 6'b011000, 6'b010010};
    imm_map[6'b001000] = 2; imm_map[6'b001001] = 2; imm_map[6'b001100] = 0; imm_map[6'b001101] = 1;
    imm_map[6'b001110] = 3; imm_map[6'b001010] = 7; imm_map[6'b001011] = 11;
    r_map[6'b100000] = 2; r_map[6'b100001] = 2; r_map[6'b100010] = 6; r_map[6'b100011] = 6;
    r_map[6'b100100] = 0; r_map[6'b100101] = 1; r_map[6'b100110] = 3; r_map[6'b100111] = 12;
    r_map[6'b101010] = 7; r_map[6'b101011] = 11; r_map[6'b000000] = 8; r_map[6'b000010] = 9;
    r_map[6'b000011] = 10;
    step(0, 0, 0, 2'b00, 6'd0, 6'd0);
    step(1, 0, 0, 2'b11, 6'd0, 6'b011000);
    idle(2);
    rop(6'b100111);
    step(1, 0, 1, 2'b10, 6'b001011, 6'd0);
    step(1, 0, 1, 2'b10, 6'b111111, 6'd0);
    step(1, 0, 1, 2'b00, 6'b100011, 6'd5);
    step(1, 0, 1, 2'b00, 6'b101011, 6'd9);
    step(1, 0, 1, 2'b01, 6'b000100, 6'd0);
    foreach (ops[i]) step(1, 0, 1, 2'b10, ops[i], 6'd0);
    foreach (r_map[k]) rop(6'(k));
    rop(6'b111111);
    rop(6'b010100);
    rop(6'b011100);
    rop(6'b011000);
    idle(1);
    for (int i = 0; i < 4; i++) rop(6'b010010);
    idle(2);
    rop(6'b011011);
    idle(DIV_LAT - 1);
    rop(6'b011010);
    rop(6'b011010);
    idle(DIV_LAT + 2);
    rop(6'b011010);
    idle(9);
    step(0, 1, 1, 2'b00, 6'd0, 6'd0);
    idle(DIV_LAT + 2);
    step(1, 1, 1, 2'b11, 6'd0, 6'b011000);
    idle(2);
    rop(6'b010001);
    rop(6'b010011);
    rop(6'b011000);
    idle(1);
    step(0, 0, 0, 2'b00, 6'd0, 6'd0);
    step(0, 0, 0, 2'b00, 6'd0, 6'd0);
    rop(6'b010000);
    idle(MUL_LAT + 2);
    for (int i = 0; i < 3000; i++) begin
      logic v, fl, rn;
      logic [1:0] ao;
      logic [5:0] oc, fn;
      v = $urandom_range(0, 9) != 0;
      fl = $urandom_range(0, 39) == 0;
      rn = $urandom_range(0, 499) != 0;
      ao = 2'($urandom_range(0, 3));
      oc = $urandom_range(0, 2) != 0 ? ops[$urandom_range(0, ops.size() - 1)] : 6'($urandom);
      fn = $urandom_range(0, 4) != 0 ? fns[$urandom_range(0, fns.size() - 1)] : 6'($urandom);
      if (ao != 2'b11 && $urandom_range(0, 1) == 0) ao = 2'b11;
      step(v, fl, rn, ao, oc, fn);
    end
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
